// File: rtl/store_buffer.sv
// Posted-write store buffer: lane-aligns MEM-stage stores into a small FIFO and drains them
// to data memory over req/ack. Define STORE_BUFFER_LDCHK_EN for per-entry load conflict checks.
module store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [3:0]  st_bes,
  output logic        st_ready,
  output logic        mem_req,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] ld_addr,
  input  logic [3:0]  ld_be,
  input  logic        ld_valid,
  output logic        ld_stall,
  output logic        sb_empty
);

  localparam logic [PTR_W:0] Full = (PTR_W+1)'(DEPTH);

  logic [29:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [3:0]       be_q   [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             bes_ok, push, pop, conflict;
  logic [31:0]      st_wdata;
  logic             unused_bits;

  // Only the seven legal store masks are accepted; anything else is dropped.
  always_comb begin
    bes_ok   = 1'b0;
    st_wdata = st_data;
    case (st_bes)
      4'b1111: bes_ok = 1'b1;
      4'b0011, 4'b1100: begin
        bes_ok   = 1'b1;
        st_wdata = {2{st_data[15:0]}};
      end
      4'b0001, 4'b0010, 4'b0100, 4'b1000: begin
        bes_ok   = 1'b1;
        st_wdata = {4{st_data[7:0]}};
      end
      default: ;
    endcase
  end

  assign st_ready = (count_q != Full);
  assign push     = st_valid & st_ready & bes_ok;
  assign mem_req  = (count_q != '0);
  assign pop      = mem_req & mem_ack;
  assign sb_empty = (count_q == '0);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage is not reset; only entries inside the count window are meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= st_addr[31:2];
      data_q[wr_ptr_q] <= st_wdata;
      be_q[wr_ptr_q]   <= st_bes;
    end
  end

  assign mem_addr  = addr_q[rd_ptr_q];
  assign mem_wdata = data_q[rd_ptr_q];
  assign mem_be    = be_q[rd_ptr_q];

`ifdef STORE_BUFFER_LDCHK_EN
  // Entry i is live when its distance from rd_ptr (mod DEPTH) is below count.
  always_comb begin
    conflict = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (({1'b0, PTR_W'(i) - rd_ptr_q} < count_q) &&
          (addr_q[i] == ld_addr[31:2]) && ((be_q[i] & ld_be) != 4'b0000)) begin
        conflict = 1'b1;
      end
    end
  end
  assign unused_bits = ^{st_addr[1:0], ld_addr[1:0]};
`else
  assign conflict    = (count_q != '0);
  assign unused_bits = ^{st_addr[1:0], ld_addr, ld_be};
`endif

  assign ld_stall = ld_valid & conflict;

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: stimulus queues expected memory writes, a monitor
// pops and compares them on every accepted mem_req/mem_ack handshake.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_bes;
  logic        st_ready;
  logic        mem_req;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] ld_addr;
  logic [3:0]  ld_be;
  logic        ld_valid;
  logic        ld_stall;
  logic        sb_empty;

  int checks = 0;
  int errors = 0;
  logic [65:0] exp_q [$];

`ifdef STORE_BUFFER_LDCHK_EN
  localparam logic LdChk = 1'b1;
`else
  localparam logic LdChk = 1'b0;
`endif

  store_buffer dut (
    .clk       (clk),
    .rst       (rst),
    .st_valid  (st_valid),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_bes    (st_bes),
    .st_ready  (st_ready),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack),
    .ld_addr   (ld_addr),
    .ld_be     (ld_be),
    .ld_valid  (ld_valid),
    .ld_stall  (ld_stall),
    .sb_empty  (sb_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_bes   = b;
  endtask

  task automatic expect_wr(input logic [29:0] a, input logic [31:0] wd, input logic [3:0] be);
    exp_q.push_back({a, wd, be});
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while (!sb_empty && n < 20) begin
      cyc();
      n++;
    end
    chk(name, {31'd0, sb_empty}, 32'd1);
  endtask

  // Monitor: every accepted write must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && mem_req === 1'b1 && mem_ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=%h/%h/%h required=none",
                 mem_addr, mem_wdata, mem_be);
      end else begin
        logic [65:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", {2'b00, mem_addr}, {2'b00, e[65:36]});
        chk("wr_data", mem_wdata, e[35:4]);
        chk("wr_be", {28'd0, mem_be}, {28'd0, e[3:0]});
      end
    end
  end

  initial begin
    rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_bes = '0;
    mem_ack = 1'b0; ld_addr = '0; ld_be = '0; ld_valid = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("idle_mem_req", {31'd0, mem_req}, 32'd0);
      chk("idle_sb_empty", {31'd0, sb_empty}, 32'd1);
      chk("idle_st_ready", {31'd0, st_ready}, 32'd1);
      chk("idle_ld_stall", {31'd0, ld_stall}, 32'd0);
      cyc();
    end

    // Byte and halfword stores with mem_ack held high.
    mem_ack = 1'b1;
    drive_st(32'h100, 32'h0000_00AB, 4'b0100);
    expect_wr(30'h40, 32'hABAB_ABAB, 4'b0100);
    cyc();
    drive_st(32'h102, 32'h0000_1234, 4'b1100);
    expect_wr(30'h40, 32'h1234_1234, 4'b1100);
    #1;
    chk("sb_latency_req", {31'd0, mem_req}, 32'd1);
    cyc();
    st_valid = 1'b0;
    #1;
    chk("sh_req", {31'd0, mem_req}, 32'd1);
    cyc();
    chk("after_drain_req", {31'd0, mem_req}, 32'd0);
    chk("after_drain_empty", {31'd0, sb_empty}, 32'd1);

    // Fill to capacity, hold, then drain with a concurrent push.
    mem_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_st(32'h300 + 32'(4 * k), 32'hA000_0000 + 32'(k), 4'b1111);
      expect_wr(30'hC0 + 30'(k), 32'hA000_0000 + 32'(k), 4'b1111);
      cyc();
    end
    drive_st(32'h400, 32'hDEAD_BEEF, 4'b1111);
    #1;
    chk("full_st_ready", {31'd0, st_ready}, 32'd0);
    cyc();
    st_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_ready", {31'd0, st_ready}, 32'd0);
      chk("hold_addr", {2'b00, mem_addr}, 32'hC0);
      chk("hold_data", mem_wdata, 32'hA000_0000);
      chk("hold_be", {28'd0, mem_be}, 32'hF);
      cyc();
    end
    mem_ack = 1'b1;
    cyc();
    drive_st(32'h310, 32'h0000_BEEF, 4'b0011);
    expect_wr(30'hC4, 32'hBEEF_BEEF, 4'b0011);
    #1;
    chk("pop_then_ready", {31'd0, st_ready}, 32'd1);
    cyc();
    st_valid = 1'b0;
    #1;
    chk("push_pop_ready", {31'd0, st_ready}, 32'd1);
    chk("push_pop_req", {31'd0, mem_req}, 32'd1);
    wait_empty("fill_drain_done");
    chk("fill_drain_queue", 32'(exp_q.size()), 32'd0);

    // Reset mid-drain discards pending stores.
    mem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive_st(32'h500 + 32'(4 * k), 32'h5000_0000 + 32'(k), 4'b1111);
      expect_wr(30'h140 + 30'(k), 32'h5000_0000 + 32'(k), 4'b1111);
      cyc();
    end
    st_valid = 1'b0;
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_sb_empty", {31'd0, sb_empty}, 32'd1);
    chk("rst_st_ready", {31'd0, st_ready}, 32'd1);
    mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst_no_req", {31'd0, mem_req}, 32'd0);
    end

    // Load conflict checks.
    mem_ack = 1'b0;
    drive_st(32'h200, 32'h1122_3344, 4'b1111);
    expect_wr(30'h80, 32'h1122_3344, 4'b1111);
    cyc();
    st_valid = 1'b0;
    ld_valid = 1'b1; ld_addr = 32'h200; ld_be = 4'b0001;
    #1;
    chk("ld_same_word", {31'd0, ld_stall}, 32'd1);
    ld_addr = 32'h204;
    #1;
    chk("ld_other_word", {31'd0, ld_stall}, {31'd0, ~LdChk});
    ld_valid = 1'b0; ld_addr = 32'h200;
    #1;
    chk("ld_not_valid", {31'd0, ld_stall}, 32'd0);
    drive_st(32'h300, 32'h0000_0055, 4'b0001);
    expect_wr(30'hC0, 32'h5555_5555, 4'b0001);
    cyc();
    st_valid = 1'b0;
    ld_valid = 1'b1; ld_addr = 32'h300; ld_be = 4'b0010;
    #1;
    chk("ld_disjoint_bytes", {31'd0, ld_stall}, {31'd0, ~LdChk});
    ld_be = 4'b0001;
    #1;
    chk("ld_overlap_bytes", {31'd0, ld_stall}, 32'd1);
    drive_st(32'h600, 32'h0000_0077, 4'b1000);
    expect_wr(30'h180, 32'h7777_7777, 4'b1000);
    ld_addr = 32'h600; ld_be = 4'b1000;
    #1;
    chk("ld_same_cycle_push", {31'd0, ld_stall}, {31'd0, ~LdChk});
    cyc();
    st_valid = 1'b0;
    #1;
    chk("ld_after_push", {31'd0, ld_stall}, 32'd1);
    ld_valid = 1'b0;
    mem_ack = 1'b1;
    wait_empty("ld_drain_done");

    // Illegal masks are dropped.
    mem_ack = 1'b0;
    drive_st(32'h700, 32'hFFFF_FFFF, 4'b0000);
    #1;
    chk("drop_ready", {31'd0, st_ready}, 32'd1);
    cyc();
    st_bes = 4'b0101;
    cyc();
    st_valid = 1'b0;
    #1;
    chk("drop_sb_empty", {31'd0, sb_empty}, 32'd1);
    chk("drop_mem_req", {31'd0, mem_req}, 32'd0);
    chk("final_queue", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
